virtual_address_sequencer: RTL and testbench

//  Parametrised successor to the single-shot virtual address register: holds the address fed to

---
 rtl/vaddr_seq_pkg.sv | 32 +++
 rtl/vaddr_source_select.sv | 25 ++
 rtl/virtual_address_sequencer.sv | 125 ++++++++++++
 tb/tb_virtual_address_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vaddr_seq_pkg.sv
// Shared types and helpers for the virtual address sequencer.
package vaddr_seq_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam int unsigned STEP_W = 3;

    // Address increment per beat; the reserved encoding steps like a word.
    function automatic logic [STEP_W-1:0] step_of(input logic [1:0] size);
        logic [STEP_W-1:0] step;
        case (size)
            SIZE_BYTE: step = 3'd1;
            SIZE_HALF: step = 3'd2;
            default:   step = 3'd4;
        endcase
        return step;
    endfunction

    // Page number of an address (zero-extended to 64 bits by the caller).
    function automatic logic [63:0] page_of(input logic [63:0] addr, input int unsigned page_bits);
        return addr >> page_bits;
    endfunction

endpackage

// File: rtl/vaddr_source_select.sv
// Load source multiplexer with out-of-range source detection.
module vaddr_source_select #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_SOURCES = 3,
    parameter int unsigned SEL_W       = 2
) (
    input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] load_data,
    input  logic [SEL_W-1:0]                  load_source,
    output logic [ADDR_WIDTH-1:0]             sel_addr_c,
    output logic                              sel_error_c
);

    // Pick the addressed slot; an out-of-range select yields zero.
    always_comb begin
        sel_addr_c = '0;
        for (int k = 0; k < int'(NUM_SOURCES); k++) begin
            if (load_source == SEL_W'(k)) begin
                sel_addr_c = load_data[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign sel_error_c = (32'(load_source) >= NUM_SOURCES);

endmodule

// File: rtl/virtual_address_sequencer.sv
// Virtual address sequencer: loads a start address from one of several
// sources, then steps it through a multi-beat access, one beat per MMU
// handshake, flagging page crossings.
// Optional start-address alignment check: define VADDR_SEQ_ALIGN_CHECK_EN.
module virtual_address_sequencer
    import vaddr_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_SOURCES = 3,
    parameter int unsigned PAGE_BITS   = 12,
    parameter int unsigned BURST_W     = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [$clog2(NUM_SOURCES)-1:0]    load_source,
    input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] load_data,
    input  logic [BURST_W-1:0]                burst_length,
    input  logic [1:0]                        access_size,
    output logic [ADDR_WIDTH-1:0]             virtual_address,
    output logic                              translate_valid,
    input  logic                              translate_ready,
    output logic [BURST_W-1:0]                beat_index,
    output logic                              page_cross,
    output logic                              sel_error,
    output logic                              align_fault
);

    localparam int unsigned SEL_W = $clog2(NUM_SOURCES);

    state_t              state;
    logic [BURST_W-1:0]  burst_len_q;
    logic [STEP_W-1:0]   step_q;

    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic                  sel_error_c;
    logic [STEP_W-1:0]     step_c;
    logic                  misaligned_c;
    logic [ADDR_WIDTH-1:0] next_addr_c;
    logic                  page_change_c;

    vaddr_source_select #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_SOURCES (NUM_SOURCES),
        .SEL_W       (SEL_W)
    ) u_source_select (
        .load_data   (load_data),
        .load_source (load_source),
        .sel_addr_c  (sel_addr_c),
        .sel_error_c (sel_error_c)
    );

    assign step_c = step_of(access_size);

`ifdef VADDR_SEQ_ALIGN_CHECK_EN
    assign misaligned_c = |(sel_addr_c & ADDR_WIDTH'(step_c - STEP_W'(1)));
`else
    assign misaligned_c = 1'b0;
`endif

    // Next beat address wraps modulo 2**ADDR_WIDTH; wrap counts as a page change.
    assign next_addr_c   = virtual_address + ADDR_WIDTH'(step_q);
    assign page_change_c = (page_of(64'(next_addr_c), PAGE_BITS) !=
                            page_of(64'(virtual_address), PAGE_BITS));

    // Load / present FSM with address stepping and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            virtual_address <= '0;
            beat_index      <= '0;
            burst_len_q     <= '0;
            step_q          <= '0;
            page_cross      <= 1'b0;
            sel_error       <= 1'b0;
            align_fault     <= 1'b0;
            load_ready      <= 1'b1;
            translate_valid <= 1'b0;
        end else begin
            sel_error   <= 1'b0;
            align_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        if (sel_error_c) begin
                            sel_error <= 1'b1;
                        end else if (misaligned_c) begin
                            align_fault <= 1'b1;
                        end else begin
                            virtual_address <= sel_addr_c;
                            burst_len_q     <= burst_length;
                            step_q          <= step_c;
                            beat_index      <= '0;
                            page_cross      <= 1'b0;
                            state           <= PRESENT;
                            load_ready      <= 1'b0;
                            translate_valid <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (translate_ready) begin
                        if (beat_index == burst_len_q) begin
                            page_cross      <= 1'b0;
                            state           <= IDLE;
                            load_ready      <= 1'b1;
                            translate_valid <= 1'b0;
                        end else begin
                            virtual_address <= next_addr_c;
                            beat_index      <= beat_index + BURST_W'(1);
                            page_cross      <= page_change_c;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    load_ready      <= 1'b1;
                    translate_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_virtual_address_sequencer.sv
// Testbench for virtual_address_sequencer: directed and randomized bursts
// against an arithmetic model of the beat sequence.
// Honours VADDR_SEQ_ALIGN_CHECK_EN to select the expected alignment behaviour.
module tb_virtual_address_sequencer;

    localparam int AW = 32;
    localparam int NS = 3;
    localparam int PB = 12;
    localparam int BW = 3;

`ifdef VADDR_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic           load_valid;
    logic           load_ready;
    logic [1:0]     load_source;
    logic [NS*AW-1:0] load_data;
    logic [BW-1:0]  burst_length;
    logic [1:0]     access_size;
    logic [AW-1:0]  virtual_address;
    logic           translate_valid;
    logic           translate_ready;
    logic [BW-1:0]  beat_index;
    logic           page_cross;
    logic           sel_error;
    logic           align_fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_addr;

    virtual_address_sequencer #(
        .ADDR_WIDTH  (AW),
        .NUM_SOURCES (NS),
        .PAGE_BITS   (PB),
        .BURST_W     (BW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_source     (load_source),
        .load_data       (load_data),
        .burst_length    (burst_length),
        .access_size     (access_size),
        .virtual_address (virtual_address),
        .translate_valid (translate_valid),
        .translate_ready (translate_ready),
        .beat_index      (beat_index),
        .page_cross      (page_cross),
        .sel_error       (sel_error),
        .align_fault     (align_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int step_for(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    task automatic chk_idle(input string tag, input logic [31:0] addr, input logic [31:0] beat);
        chk({tag, "_tv"},    32'(translate_valid), 32'd0);
        chk({tag, "_ready"}, 32'(load_ready),      32'd1);
        chk({tag, "_addr"},  virtual_address,      addr);
        chk({tag, "_beat"},  32'(beat_index),      beat);
        chk({tag, "_pc"},    32'(page_cross),      32'd0);
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        load_valid      = 1'b0;
        translate_ready = 1'b0;
        tick();
        chk_idle("rst", 32'd0, 32'd0);
        chk("rst_sel", 32'(sel_error),   32'd0);
        chk("rst_al",  32'(align_fault), 32'd0);
        tick();
        reset = 1'b0;
        last_addr = 32'd0;
    endtask

    // One load plus the full burst; expected beats come from start + k*step.
    task automatic run_burst(input int src, input logic [31:0] start, input logic [1:0] size,
                             input int len, input int stall_at, input int stall_n,
                             input int max_stall);
        int          step;
        int          n;
        logic [31:0] a;
        logic [31:0] a_last;
        logic        exp_pc;
        logic [NS*AW-1:0] d;

        step = step_for(size);
        d = {$urandom(), $urandom(), $urandom()};
        d[src*AW +: AW] = start;
        chk("pre_load_ready", 32'(load_ready), 32'd1);
        load_valid   = 1'b1;
        load_source  = 2'(src);
        load_data    = d;
        burst_length = 3'(len);
        access_size  = size;
        tick();
        load_valid   = 1'b0;
        load_data    = {$urandom(), $urandom(), $urandom()};
        burst_length = 3'($urandom());
        access_size  = 2'($urandom());

        if (ALIGN_EN && ((start & 32'(step - 1)) != 32'd0)) begin
            chk("align_fault", 32'(align_fault), 32'd1);
            chk_idle("align_idle", last_addr, 32'(beat_index));
            tick();
            chk("align_fault_end", 32'(align_fault), 32'd0);
            return;
        end
        chk("load_al", 32'(align_fault), 32'd0);
        chk("load_sel", 32'(sel_error), 32'd0);

        for (int k = 0; k <= len; k++) begin
            a = start + 32'(k * step);
            exp_pc = (k > 0) && ((a >> PB) != ((a - 32'(step)) >> PB));
            chk("beat_tv",    32'(translate_valid), 32'd1);
            chk("beat_ready", 32'(load_ready),      32'd0);
            chk("beat_addr",  virtual_address,      a);
            chk("beat_idx",   32'(beat_index),      32'(k));
            chk("beat_pc",    32'(page_cross),      32'(exp_pc));
            n = ((k == stall_at) ? stall_n : 0) + $urandom_range(max_stall, 0);
            for (int s = 0; s < n; s++) begin
                translate_ready = 1'b0;
                tick();
                chk("stall_tv",   32'(translate_valid), 32'd1);
                chk("stall_addr", virtual_address,      a);
                chk("stall_idx",  32'(beat_index),      32'(k));
                chk("stall_pc",   32'(page_cross),      32'(exp_pc));
            end
            translate_ready = 1'b1;
            tick();
            translate_ready = 1'b0;
        end
        a_last = start + 32'(len * step);
        chk_idle("done", a_last, 32'(len));
        last_addr = a_last;
    endtask

    initial begin
        load_source  = 2'd0;
        load_data    = '0;
        burst_length = '0;
        access_size  = 2'd0;
        apply_reset();

        // Single word beat
        run_burst(1, 32'h0000_1000, 2'd2, 0, -1, 0, 0);
        // Word burst crossing into page 1
        run_burst(0, 32'h0000_0FF8, 2'd2, 3, -1, 0, 0);
        // Byte burst wrapping the address space
        run_burst(2, 32'hFFFF_FFFE, 2'd0, 2, -1, 0, 0);
        // Five-cycle stall on the second beat
        run_burst(0, 32'h0000_2000, 2'd1, 1, 1, 5, 0);

        // Out-of-range source
        load_valid  = 1'b1;
        load_source = 2'd3;
        load_data   = {$urandom(), $urandom(), $urandom()};
        tick();
        load_valid = 1'b0;
        chk("sel_error", 32'(sel_error), 32'd1);
        chk("sel_al",    32'(align_fault), 32'd0);
        chk_idle("sel_idle", last_addr, 32'(beat_index));
        tick();
        chk("sel_error_end", 32'(sel_error), 32'd0);

        // Misaligned word start
        run_burst(0, 32'h0000_1002, 2'd2, 3, -1, 0, 0);

        // Randomized bursts, half of them starting just below a page boundary
        for (int i = 0; i < 25; i++) begin
            logic [31:0] st;
            if ($urandom_range(1, 0) == 1)
                st = ($urandom() & 32'hFFFF_F000) - 32'($urandom_range(16, 1));
            else
                st = $urandom();
            run_burst($urandom_range(NS - 1, 0), st, 2'($urandom()),
                      $urandom_range(7, 0), -1, 0, 2);
        end

        // Reset in the middle of a four-beat burst
        load_valid   = 1'b1;
        load_source  = 2'd1;
        load_data    = {32'h0, 32'h0000_3000, 32'h0};
        burst_length = 3'd3;
        access_size  = 2'd2;
        tick();
        load_valid      = 1'b0;
        translate_ready = 1'b1;
        tick();
        tick();
        translate_ready = 1'b0;
        chk("mid_addr", virtual_address, 32'h0000_3008);
        chk("mid_idx",  32'(beat_index), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("mid_rst", 32'd0, 32'd0);
        tick();
        chk_idle("post_rst", 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
